// File: rtl/prog_clk_div_pkg.sv
// prog_clk_div shared constants and helpers.
// Divisor clamping and high-phase length.
package prog_clk_div_pkg;

  localparam int DIV_MIN   = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 9;

  function automatic logic [31:0] clamp_div(
    input logic [31:0] v
  );
    return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
  endfunction

  // Odd divisors put the extra cycle in the high phase.
  function automatic logic [31:0] hi_of(
    input logic [31:0] n
  );
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/div_cfg_reg.sv
// Divisor configuration: pending capture, clamp/error flag,
// apply at a period boundary and one-cycle acknowledge.
module div_cfg_reg
  import prog_clk_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  input  logic             boundary,
  output logic [WIDTH-1:0] active_nxt,
  output logic [WIDTH-1:0] active_div,
  output logic             div_ack,
  output logic             div_err
);

  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  always_comb begin
    pend_val_d = pend_val_q;
    active_d   = active_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    if (boundary && pend_q) begin
      active_d = pend_val_q;
      pend_d   = 1'b0;
      ack_d    = 1'b1;
    end
    // A load on the apply edge queues for the next boundary.
    if (div_load) begin
      pend_val_d = WIDTH'(clamp_div(32'(div_value)));
      pend_d     = 1'b1;
      if (32'(div_value) < 32'(DIV_MIN))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_val_q <= '0;
      active_q   <= WIDTH'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_val_q <= pend_val_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign active_nxt = active_d;
  assign active_div = active_q;
  assign div_ack    = ack_q;
  assign div_err    = err_q;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable integer clock divider with registered out/tick.
// Optional PROG_CLK_DIV_GATE_EN adds an `en` period gate.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PROG_CLK_DIV_GATE_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] active_div,
  output logic             out,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_nxt;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap, run, boundary;

`ifdef PROG_CLK_DIV_GATE_EN
  assign run = en;
`else
  assign run = 1'b1;
`endif

  div_cfg_reg #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_cfg (
    .clk        (clk),
    .reset      (reset),
    .div_value  (div_value),
    .div_load   (div_load),
    .boundary   (boundary),
    .active_nxt (active_nxt),
    .active_div (active_div),
    .div_ack    (div_ack),
    .div_err    (div_err)
  );

  // Gated: cnt parks on the last count, which keeps out low.
  always_comb begin
    wrap     = (cnt_q == active_div - WIDTH'(1));
    boundary = wrap && run;
    cnt_d    = cnt_q;
    if (boundary)
      cnt_d = '0;
    else if (!wrap)
      cnt_d = cnt_q + WIDTH'(1);
    out_d  = 32'(cnt_d) < hi_of(32'(active_nxt));
    tick_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= WIDTH'(DEFAULT_DIV - 1);
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: queue scoreboard fed by a period
// model, plus fixed out/tick pattern tables.
module tb_prog_clk_div;

  typedef struct packed {
    logic       o;
    logic       t;
    logic       a;
    logic       e;
    logic [7:0] n;
  } exp_t;

  typedef struct {
    logic ld;
    logic [7:0] v;
    logic o;
    logic t;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [7:0] div_value = '0;
  logic       div_load = 1'b0;
  logic       div_ack, div_err, out, tick;
  logic [7:0] active_div;

  int n_vec = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int tick_cnt = 0;

  int m_cnt, m_n, m_pv;
  bit m_pend, m_err;

  exp_t sb_q[$];
  vec_t pat9[9];
  vec_t pat4[4];

  always #5 clk = ~clk;

  prog_clk_div dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PROG_CLK_DIV_GATE_EN
    .en         (en),
`endif
    .div_value  (div_value),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .active_div (active_div),
    .out        (out),
    .tick       (tick)
  );

  task automatic chk(input string nm,
                     input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic rs, input logic ld,
                      input logic [7:0] v, input logic g);
    exp_t e, got;
    reset = rs;
    div_load = ld;
    div_value = v;
    en = g;
    e = '0;
    if (!rs) begin
      m_cnt = 8; m_n = 9; m_pv = 0;
      m_pend = 0; m_err = 0;
    end else begin
      if (m_cnt == m_n - 1) begin
        if (g) begin
          m_cnt = 0;
          e.t = 1'b1;
          if (m_pend) begin
            m_n = m_pv; m_pend = 0; e.a = 1'b1;
          end
        end
      end else begin
        m_cnt++;
      end
      if (ld) begin
        m_pv = (v < 2) ? 2 : int'(v);
        m_pend = 1;
        if (v < 2) m_err = 1;
      end
    end
    e.o = (m_cnt < (m_n + 1) / 2);
    e.e = m_err;
    e.n = 8'(m_n);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    div_load = 1'b0;
    got = {out, tick, div_ack, div_err, active_div};
    if (sb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_empty: no expected entry");
    end else begin
      e = sb_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL sb t=%0t: got %h want %h",
                 $time, got, e);
      end
    end
    if (div_ack) ack_cnt++;
    if (tick) tick_cnt++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 1);
  endtask

  task automatic wait_cnt(input int c);
    int b;
    b = 0;
    while (m_cnt != c && b < 600) begin
      step(1, 0, 0, 1);
      b++;
    end
    if (m_cnt != c) begin
      n_vec++; n_bad++;
      $display("FAIL wait_cnt: got %0d want %0d", m_cnt, c);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++)
      pat9[i] = '{1'b0, 8'd0, (i < 5), (i == 0)};
    for (int i = 0; i < 4; i++)
      pat4[i] = '{1'b0, 8'd0, (i < 2), (i == 0)};

    // reset for three cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("rst_out", int'(out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_active", int'(active_div), 9);

    // default divide-by-9, two periods from release
    for (int i = 0; i < 18; i++) begin
      step(1, pat9[i % 9].ld, pat9[i % 9].v, 1);
      chk("pat9_out", int'(out), int'(pat9[i % 9].o));
      chk("pat9_tick", int'(tick), int'(pat9[i % 9].t));
    end

    // load 4 at cnt=2; applies on wrap 8->0
    ack_cnt = 0;
    wait_cnt(2);
    step(1, 1, 8'd4, 1);
    begin
      int b;
      b = 0;
      while (!div_ack && b < 20) begin
        chk("n4_hold", int'(active_div), 9);
        idle(1);
        b++;
      end
    end
    chk("n4_ack", int'(div_ack), 1);
    chk("n4_active", int'(active_div), 4);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(1);
      chk("pat4_out", int'(out), int'(pat4[i % 4].o));
      chk("pat4_tick", int'(tick), int'(pat4[i % 4].t));
    end
    chk("n4_acks", ack_cnt, 1);

    // loads below the minimum clamp to 2 and set div_err
    step(1, 1, 8'd0, 1);
    step(1, 1, 8'd1, 1);
    idle(8);
    chk("err_set", int'(div_err), 1);
    chk("clamp_active", int'(active_div), 2);
    idle(6);
    chk("err_sticky", int'(div_err), 1);

    // two loads in one period: last wins, single ack
    step(1, 1, 8'd9, 1);
    idle(12);
    ack_cnt = 0;
    wait_cnt(2);
    step(1, 1, 8'd5, 1);
    step(1, 1, 8'd7, 1);
    idle(20);
    chk("multi_acks", ack_cnt, 1);
    chk("multi_active", int'(active_div), 7);
    wait_cnt(6);
    begin
      int hi_n;
      hi_n = 0;
      for (int i = 0; i < 7; i++) begin
        idle(1);
        hi_n += int'(out);
      end
      chk("n7_high", hi_n, 4);
    end

    // max divisor, then same-value load on the wrap edge
    step(1, 1, 8'd255, 1);
    idle(270);
    chk("n255_active", int'(active_div), 255);
    ack_cnt = 0;
    wait_cnt(254);
    step(1, 1, 8'd255, 1);
    chk("same_edge_ack", int'(div_ack), 0);
    idle(256);
    chk("same_val_acks", ack_cnt, 1);

    // pending load dropped by reset mid-period
    step(1, 1, 8'd6, 1);
    idle(8);
    step(1, 1, 8'd6, 1);
    wait_cnt(3);
    step(0, 0, 0, 1);
    chk("rst2_out", int'(out), 0);
    chk("rst2_active", int'(active_div), 9);
    chk("rst2_err", int'(div_err), 0);
    ack_cnt = 0;
    idle(25);
    chk("rst2_acks", ack_cnt, 0);
    chk("rst2_keep9", int'(active_div), 9);

`ifdef PROG_CLK_DIV_GATE_EN
    // gate low mid-period, load while parked, reopen
    wait_cnt(2);
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    tick_cnt = 0;
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    chk("gate_ticks", tick_cnt, 0);
    chk("gate_out", int'(out), 0);
    step(1, 1, 8'd3, 0);
    step(1, 0, 0, 0);
    chk("gate_noapply", int'(active_div), 9);
    step(1, 0, 0, 1);
    chk("ungate_out", int'(out), 1);
    chk("ungate_tick", int'(tick), 1);
    chk("ungate_ack", int'(div_ack), 1);
    idle(9);
`endif

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
